// File: rtl/axi_dma_job_sequencer.sv
// Descriptor-queue front end for axi_dma: buffers read/write job descriptors and
// issues them one at a time, waiting for both completions (or a timeout) per job.
module axi_dma_job_sequencer #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DESC_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_WIDTH-1:0] desc_rd_addr,
  input  logic [ADDR_WIDTH-1:0] desc_wr_addr,
  input  logic [31:0]           desc_rd_len,
  input  logic [31:0]           desc_wr_len,
  output logic [ADDR_WIDTH-1:0] axi_read_start_addr,
  output logic [ADDR_WIDTH-1:0] axi_write_start_addr,
  output logic [31:0]           axi_read_length,
  output logic [31:0]           axi_write_length,
  output logic                  init_read,
  output logic                  init_write,
  input  logic                  read_done,
  input  logic                  write_done,
  output logic                  busy,
  output logic                  job_done,
  output logic [CNT_WIDTH-1:0]  jobs_completed,
  output logic                  timeout_err,
  input  logic                  err_clear
);

  localparam int PW = $clog2(DESC_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KICK  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           rd_len;
    logic [31:0]           wr_len;
  } desc_t;

  desc_t           mem_q [DESC_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]     count_q, count_d;
  logic            full_s, empty_s, push_s, pop_s;
  desc_t           head_s;

  state_t                state_q, state_d;
  logic                  rd_seen_q, rd_seen_d, wr_seen_q, wr_seen_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [31:0]           rd_len_q, rd_len_d, wr_len_q, wr_len_d;
  logic                  init_read_q, init_read_d, init_write_q, init_write_d;
  logic                  busy_q, busy_d, job_done_q, job_done_d;
  logic [CNT_WIDTH-1:0]  jobs_q, jobs_d;
  logic                  err_q, err_d;

  assign full_s  = (count_q == (PW+1)'(DESC_DEPTH));
  assign empty_s = (count_q == '0);
  assign head_s  = mem_q[rptr_q];
  assign pop_s   = (state_q == S_IDLE) && enable && !empty_s && !err_q;
  // A pop in the same cycle frees a slot, so a full FIFO may still accept.
  assign desc_ready = !full_s || pop_s;
  assign push_s     = desc_valid && desc_ready;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + (PW+1)'(push_s) - (PW+1)'(pop_s);
    if (push_s) wptr_d = wptr_q + PW'(1);
    else        wptr_d = wptr_q;
    if (pop_s)  rptr_d = rptr_q + PW'(1);
    else        rptr_d = rptr_q;
  end

  // Descriptor storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wptr_q] <= '{desc_rd_addr, desc_wr_addr, desc_rd_len, desc_wr_len};
  end

  // Job FSM next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    rd_seen_d    = rd_seen_q;
    wr_seen_d    = wr_seen_q;
    tmo_cnt_d    = tmo_cnt_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    rd_len_d     = rd_len_q;
    wr_len_d     = wr_len_q;
    init_read_d  = 1'b0;
    init_write_d = 1'b0;
    job_done_d   = 1'b0;
    jobs_d       = jobs_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          rd_addr_d = head_s.rd_addr;
          wr_addr_d = head_s.wr_addr;
          rd_len_d  = head_s.rd_len;
          wr_len_d  = head_s.wr_len;
          state_d   = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        rd_seen_d    = 1'b0;
        wr_seen_d    = 1'b0;
        tmo_cnt_d    = '0;
        init_read_d  = (rd_len_q != 32'd0);
        init_write_d = (wr_len_q != 32'd0);
        state_d      = S_KICK;
      end
      S_KICK: begin
        rd_seen_d = (rd_len_q == 32'd0);
        wr_seen_d = (wr_len_q == 32'd0);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        rd_seen_d = rd_seen_q | read_done;
        wr_seen_d = wr_seen_q | write_done;
        if (rd_seen_q && wr_seen_q) begin
          job_done_d = 1'b1;
          jobs_d     = jobs_q + CNT_WIDTH'(1);
          state_d    = S_DONE;
        end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (err_clear) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_ERROR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, FIFO control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      rd_seen_q    <= 1'b0;
      wr_seen_q    <= 1'b0;
      tmo_cnt_q    <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      rd_len_q     <= '0;
      wr_len_q     <= '0;
      init_read_q  <= 1'b0;
      init_write_q <= 1'b0;
      busy_q       <= 1'b0;
      job_done_q   <= 1'b0;
      jobs_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      rd_seen_q    <= rd_seen_d;
      wr_seen_q    <= wr_seen_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      rd_len_q     <= rd_len_d;
      wr_len_q     <= wr_len_d;
      init_read_q  <= init_read_d;
      init_write_q <= init_write_d;
      busy_q       <= busy_d;
      job_done_q   <= job_done_d;
      jobs_q       <= jobs_d;
      err_q        <= err_d;
    end
  end

  assign axi_read_start_addr  = rd_addr_q;
  assign axi_write_start_addr = wr_addr_q;
  assign axi_read_length      = rd_len_q;
  assign axi_write_length     = wr_len_q;
  assign init_read            = init_read_q;
  assign init_write           = init_write_q;
  assign busy                 = busy_q;
  assign job_done             = job_done_q;
  assign jobs_completed       = jobs_q;
  assign timeout_err          = err_q;

endmodule
